comparator_serial_nbit: RTL

COMPARATOR_SERIAL_NBIT -- requirements
Module: comparator_serial_nbit

---
 rtl/comparator_defs.sv | 15 +
 rtl/comparator_nbit.sv | 35 +++
 rtl/comparator_serial_nbit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/comparator_defs.sv
// ---------------------------------------------------------------------------
// comparator_defs
// Shared definitions for the comparator family of blocks.
//   cmp_state_e : binary-encoded control states used by serial comparators
//                 (IDLE waits for start, RUN walks the digits, DONE pulses).
// ---------------------------------------------------------------------------
package comparator_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } cmp_state_e;

endpackage : comparator_defs

// File: rtl/comparator_nbit.sv
// ---------------------------------------------------------------------------
// comparator_nbit
// Purely combinational unsigned magnitude comparator.
// Ports:
//   a, b     : input  [N-1:0] unsigned operands
//   smaller  : output         a <  b
//   equal    : output         a == b
//   greater  : output         a >  b
// Exactly one of the three outputs is high at any time.
// ---------------------------------------------------------------------------
module comparator_nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         smaller,
    output logic         equal,
    output logic         greater
);

    // One-hot magnitude decision
    always_comb begin
        smaller = 1'b0;
        equal   = 1'b0;
        greater = 1'b0;
        if (a < b) begin
            smaller = 1'b1;
        end else if (a > b) begin
            greater = 1'b1;
        end else begin
            equal = 1'b1;
        end
    end

endmodule : comparator_nbit

// File: rtl/comparator_serial_nbit.sv
// ---------------------------------------------------------------------------
// comparator_serial_nbit
// Digit-serial magnitude comparator. Operands are captured on start and
// compared D bits per cycle, most significant digit first. The comparison
// stops at the first differing digit, so latency is 1..N/D cycles.
// Ports:
//   clk       : input          rising-edge clock
//   reset     : input          asynchronous active-high reset
//   start     : input          begin a comparison (only honoured in IDLE)
//   a, b      : input  [N-1:0] operands, captured on accepted start
//   is_signed : input          1 = two's-complement, 0 = unsigned
//   busy      : output         high while digits are being compared
//   done      : output         one-cycle pulse marking a fresh result
//   smaller   : output         registered a <  b
//   equal     : output         registered a == b
//   greater   : output         registered a >  b
// ---------------------------------------------------------------------------
module comparator_serial_nbit
    import comparator_defs::*;
#(
    parameter int N = 12,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_signed,
    output logic         busy,
    output logic         done,
    output logic         smaller,
    output logic         equal,
    output logic         greater
);

    localparam int DIGITS = N / D;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    // Reject widths that do not split into whole digits
    generate
        if ((N % D) != 0) begin : g_bad_width
            $error("comparator_serial_nbit: N must be a multiple of D");
        end
    endgenerate

    cmp_state_e    state_r;
    cmp_state_e    next_state_s;
    logic [N-1:0]  a_sh_r;
    logic [N-1:0]  b_sh_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;
    logic          done_r;
    logic          smaller_r;
    logic          equal_r;
    logic          greater_r;

    logic          load_s;
    logic [N-1:0]  msb_flip_s;
    logic [D-1:0]  a_dig_s;
    logic [D-1:0]  b_dig_s;
    logic          dig_lt_s;
    logic          dig_eq_s;
    logic          dig_gt_s;

    assign a_dig_s = a_sh_r[N-1 -: D];
    assign b_dig_s = b_sh_r[N-1 -: D];

    comparator_nbit #(
        .N (D)
    ) u_digit_cmp (
        .a       (a_dig_s),
        .b       (b_dig_s),
        .smaller (dig_lt_s),
        .equal   (dig_eq_s),
        .greater (dig_gt_s)
    );

    // Signed operands become offset-binary by inverting the sign bit, so
    // the unsigned digit walk orders them correctly.
    always_comb begin
        msb_flip_s        = '0;
        msb_flip_s[N-1]   = is_signed;
    end

    // Next-state decode: early exit on the first unequal digit
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_RUN;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!dig_eq_s) begin
                    next_state_s = ST_DONE;
                end else if (cnt_r == LAST_DIGIT) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, operand shifters, digit counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            a_sh_r    <= '0;
            b_sh_r    <= '0;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            smaller_r <= 1'b0;
            equal_r   <= 1'b0;
            greater_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_RUN);
            done_r  <= (next_state_s == ST_DONE);
            if (load_s) begin
                a_sh_r <= a ^ msb_flip_s;
                b_sh_r <= b ^ msb_flip_s;
                cnt_r  <= '0;
            end else if (state_r == ST_RUN) begin
                a_sh_r <= a_sh_r << D;
                b_sh_r <= b_sh_r << D;
                cnt_r  <= cnt_r + CW'(1);
                // On the final equal digit the compare itself reports equal
                if (next_state_s == ST_DONE) begin
                    smaller_r <= dig_lt_s;
                    equal_r   <= dig_eq_s;
                    greater_r <= dig_gt_s;
                end
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign smaller = smaller_r;
    assign equal   = equal_r;
    assign greater = greater_r;

endmodule : comparator_serial_nbit
